// File: rtl/gf2_solve_sequencer.sv
// Job controller for the GF(2) solver path: sequences gf2_rref then enumerate_solutions,
// reports each job's minimum solution weight and accumulates the minima over a batch.
module gf2_solve_sequencer #(
  parameter  int MAX_ROWS = 8,
  parameter  int MAX_COLS = 9,
  parameter  int SUM_W    = 16,
  localparam int ROWS_W   = $clog2(MAX_ROWS+1),
  localparam int COLS_W   = $clog2(MAX_COLS+1),
  localparam int WT_W     = $clog2(MAX_COLS),
  localparam int MAT_W    = MAX_ROWS*MAX_COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ROWS_W-1:0] job_rows,
  input  logic [COLS_W-1:0] job_cols,
  input  logic [MAT_W-1:0]  job_matrix,
  input  logic              job_last,
  output logic              rref_start,
  output logic [ROWS_W-1:0] rref_rows,
  output logic [COLS_W-1:0] rref_cols,
  output logic [MAT_W-1:0]  rref_matrix,
  input  logic              rref_done,
  input  logic              rref_inconsistent,
  input  logic [MAT_W-1:0]  rref_result,
  output logic              enum_start,
  output logic [ROWS_W-1:0] enum_rows,
  output logic [COLS_W-1:0] enum_cols,
  output logic [MAT_W-1:0]  enum_rref,
  input  logic              sol_tvalid,
  output logic              sol_tready,
  input  logic [7:0]        sol_tdata,
  input  logic              sol_tlast,
  output logic              job_wt_valid,
  output logic [WT_W-1:0]   job_wt,
  output logic              job_nosol,
  output logic              total_valid,
  output logic [SUM_W-1:0]  total,
  output logic              total_ovf
);
  localparam int ACC_W = ((SUM_W > WT_W) ? SUM_W : WT_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RREF_GO, S_RREF_WAIT, S_ENUM_GO, S_COLLECT, S_REPORT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROWS_W-1:0] rref_rows_q, rref_rows_d, enum_rows_q, enum_rows_d;
  logic [COLS_W-1:0] rref_cols_q, rref_cols_d, enum_cols_q, enum_cols_d;
  logic [MAT_W-1:0]  rref_matrix_q, rref_matrix_d, enum_rref_q, enum_rref_d;
  logic              last_q, last_d, nosol_q, nosol_d;
  logic [WT_W-1:0]   best_q, best_d, job_wt_q, job_wt_d;
  logic              job_nosol_q, job_nosol_d;
  logic [SUM_W-1:0]  total_q, total_d;
  logic              total_ovf_q, total_ovf_d;
  logic              job_ready_q, job_ready_d, rref_start_q, rref_start_d;
  logic              enum_start_q, enum_start_d, sol_tready_q, sol_tready_d;
  logic              job_wt_valid_q, job_wt_valid_d, total_valid_q, total_valid_d;
  logic [WT_W-1:0]   beat_wt;
  logic [ACC_W-1:0]  acc;

  function automatic logic [WT_W-1:0] popcount8(input logic [7:0] b);
    logic [WT_W-1:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + WT_W'(b[i]);
    return c;
  endfunction

  assign beat_wt = popcount8(sol_tdata);
  assign acc     = ACC_W'(total_q) + ACC_W'(best_q);

  always_comb begin
    state_d       = state_q;
    rref_rows_d   = rref_rows_q;
    rref_cols_d   = rref_cols_q;
    rref_matrix_d = rref_matrix_q;
    enum_rows_d   = enum_rows_q;
    enum_cols_d   = enum_cols_q;
    enum_rref_d   = enum_rref_q;
    last_d        = last_q;
    nosol_d       = nosol_q;
    best_d        = best_q;
    total_d       = total_q;
    total_ovf_d   = total_ovf_q;
    case (state_q)
      S_IDLE: if (job_valid) begin
        rref_rows_d   = job_rows;
        rref_cols_d   = job_cols;
        rref_matrix_d = job_matrix;
        last_d        = job_last;
        nosol_d       = 1'b0;
        // last_q still holds the previous job's flag: a finished batch is cleared only now
        if (last_q) begin
          total_d     = '0;
          total_ovf_d = 1'b0;
        end
        state_d = S_RREF_GO;
      end
      S_RREF_GO: state_d = S_RREF_WAIT;
      S_RREF_WAIT: if (rref_done) begin
        if (rref_inconsistent) begin
          nosol_d = 1'b1;
          state_d = S_REPORT;
        end else begin
          enum_rref_d = rref_result;
          enum_rows_d = rref_rows_q;
          enum_cols_d = rref_cols_q;
          best_d      = '1;
          state_d     = S_ENUM_GO;
        end
      end
      S_ENUM_GO: state_d = S_COLLECT;
      S_COLLECT: if (sol_tvalid) begin
        if (beat_wt < best_q) best_d = beat_wt;
        if (sol_tlast) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (!nosol_q) begin
          total_d = acc[SUM_W-1:0];
          if (|acc[ACC_W-1:SUM_W]) total_ovf_d = 1'b1;
        end
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is valid for exactly that state.
  always_comb begin
    job_ready_d    = (state_d == S_IDLE);
    rref_start_d   = (state_d == S_RREF_GO);
    enum_start_d   = (state_d == S_ENUM_GO);
    sol_tready_d   = (state_d == S_COLLECT);
    job_wt_valid_d = (state_d == S_REPORT);
    total_valid_d  = (state_d == S_DONE);
    job_wt_d       = job_wt_q;
    job_nosol_d    = job_nosol_q;
    if (state_d == S_REPORT) begin
      job_wt_d    = nosol_d ? '0 : best_d;
      job_nosol_d = nosol_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rref_rows_q    <= '0;
      rref_cols_q    <= '0;
      rref_matrix_q  <= '0;
      enum_rows_q    <= '0;
      enum_cols_q    <= '0;
      enum_rref_q    <= '0;
      last_q         <= 1'b0;
      nosol_q        <= 1'b0;
      best_q         <= '0;
      job_wt_q       <= '0;
      job_nosol_q    <= 1'b0;
      total_q        <= '0;
      total_ovf_q    <= 1'b0;
      job_ready_q    <= 1'b1;
      rref_start_q   <= 1'b0;
      enum_start_q   <= 1'b0;
      sol_tready_q   <= 1'b0;
      job_wt_valid_q <= 1'b0;
      total_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rref_rows_q    <= rref_rows_d;
      rref_cols_q    <= rref_cols_d;
      rref_matrix_q  <= rref_matrix_d;
      enum_rows_q    <= enum_rows_d;
      enum_cols_q    <= enum_cols_d;
      enum_rref_q    <= enum_rref_d;
      last_q         <= last_d;
      nosol_q        <= nosol_d;
      best_q         <= best_d;
      job_wt_q       <= job_wt_d;
      job_nosol_q    <= job_nosol_d;
      total_q        <= total_d;
      total_ovf_q    <= total_ovf_d;
      job_ready_q    <= job_ready_d;
      rref_start_q   <= rref_start_d;
      enum_start_q   <= enum_start_d;
      sol_tready_q   <= sol_tready_d;
      job_wt_valid_q <= job_wt_valid_d;
      total_valid_q  <= total_valid_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign rref_start   = rref_start_q;
  assign rref_rows    = rref_rows_q;
  assign rref_cols    = rref_cols_q;
  assign rref_matrix  = rref_matrix_q;
  assign enum_start   = enum_start_q;
  assign enum_rows    = enum_rows_q;
  assign enum_cols    = enum_cols_q;
  assign enum_rref    = enum_rref_q;
  assign sol_tready   = sol_tready_q;
  assign job_wt_valid = job_wt_valid_q;
  assign job_wt       = job_wt_q;
  assign job_nosol    = job_nosol_q;
  assign total_valid  = total_valid_q;
  assign total        = total_q;
  assign total_ovf    = total_ovf_q;
endmodule

// File: tb/tb_gf2_solve_sequencer.sv
// Randomized bench for gf2_solve_sequencer: two instances (SUM_W=16 and SUM_W=2) share stimulus,
// engines are emulated here and results are checked against a batch-level weight model.
module tb_gf2_solve_sequencer;
  localparam int MR = 8, MC = 9, MW = MR*MC;
  localparam logic [5:0] C_RDY = 6'b100000, C_RS = 6'b010000, C_ES = 6'b001000,
                         C_TR  = 6'b000100, C_WV = 6'b000010, C_TV = 6'b000001, C_NONE = 6'b0;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic job_valid = 0, job_last = 0, rref_done = 0, rref_inconsistent = 0;
  logic sol_tvalid = 0, sol_tlast = 0;
  logic [3:0] job_rows = '0, job_cols = '0;
  logic [MW-1:0] job_matrix = '0, rref_result = '0;
  logic [7:0] sol_tdata = '0;

  logic a_rdy, a_rs, a_es, a_tr, a_wv, a_nos, a_tv, a_ovf;
  logic b_rdy, b_rs, b_es, b_tr, b_wv, b_nos, b_tv, b_ovf;
  logic [3:0] a_rr, a_rc, a_er, a_ec, a_wt, b_rr, b_rc, b_er, b_ec, b_wt;
  logic [MW-1:0] a_rm, a_em, b_rm, b_em;
  logic [15:0] a_tot;
  logic [1:0]  b_tot;

  gf2_solve_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(a_rdy), .job_rows(job_rows),
    .job_cols(job_cols), .job_matrix(job_matrix), .job_last(job_last), .rref_start(a_rs),
    .rref_rows(a_rr), .rref_cols(a_rc), .rref_matrix(a_rm), .rref_done(rref_done),
    .rref_inconsistent(rref_inconsistent), .rref_result(rref_result), .enum_start(a_es),
    .enum_rows(a_er), .enum_cols(a_ec), .enum_rref(a_em), .sol_tvalid(sol_tvalid),
    .sol_tready(a_tr), .sol_tdata(sol_tdata), .sol_tlast(sol_tlast), .job_wt_valid(a_wv),
    .job_wt(a_wt), .job_nosol(a_nos), .total_valid(a_tv), .total(a_tot), .total_ovf(a_ovf));

  gf2_solve_sequencer #(.SUM_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(b_rdy), .job_rows(job_rows),
    .job_cols(job_cols), .job_matrix(job_matrix), .job_last(job_last), .rref_start(b_rs),
    .rref_rows(b_rr), .rref_cols(b_rc), .rref_matrix(b_rm), .rref_done(rref_done),
    .rref_inconsistent(rref_inconsistent), .rref_result(rref_result), .enum_start(b_es),
    .enum_rows(b_er), .enum_cols(b_ec), .enum_rref(b_em), .sol_tvalid(sol_tvalid),
    .sol_tready(b_tr), .sol_tdata(sol_tdata), .sol_tlast(sol_tlast), .job_wt_valid(b_wv),
    .job_wt(b_wt), .job_nosol(b_nos), .total_valid(b_tv), .total(b_tot), .total_ovf(b_ovf));

  int n_vec = 0, n_err = 0;
  int bsum = 0;          // true (unwrapped) batch sum of solvable-job minima
  bit prev_last = 0;
  logic [7:0] beats[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    check({tag, " ctl16"}, {a_rdy, a_rs, a_es, a_tr, a_wv, a_tv}, exp);
    check({tag, " ctl2"},  {b_rdy, b_rs, b_es, b_tr, b_wv, b_tv}, exp);
  endtask

  task automatic chk_tot(input string tag);
    check({tag, " total16"}, a_tot, bsum % 65536);
    check({tag, " ovf16"},   a_ovf, bsum >= 65536);
    check({tag, " total2"},  b_tot, bsum % 4);
    check({tag, " ovf2"},    b_ovf, bsum >= 4);
  endtask

  // Runs one job end to end; abort >= 0 pulses reset right after accepting that beat index.
  task automatic run_job(input int rows, input int cols, input logic [MW-1:0] mat, input bit last,
                         input bit incons, input int rdly, input bit stray, input int abort);
    int exp_wt;
    logic [MW-1:0] res;
    logic [95:0] r96;
    bit rdy;
    int n;
    chk_ctl("idle", C_RDY);
    job_valid = 1; job_rows = 4'(rows); job_cols = 4'(cols); job_matrix = mat; job_last = last;
    tick();
    job_valid = 0; job_last = 0;
    if (prev_last) bsum = 0;
    prev_last = last;
    chk_ctl("rref_go", C_RS);
    check("rref_rows", {a_rr, b_rr}, {4'(rows), 4'(rows)});
    check("rref_cols", {a_rc, b_rc}, {4'(cols), 4'(cols)});
    check("rref_matrix", {a_rm, b_rm}, {mat, mat});
    chk_tot("handshake");
    sol_tvalid = stray; sol_tlast = stray; sol_tdata = 8'h00;
    tick();
    chk_ctl("rref_wait", C_NONE);
    for (int i = 0; i < rdly; i++) begin tick(); chk_ctl("rref_wait", C_NONE); end
    r96 = {$urandom(), $urandom(), $urandom()};
    res = r96[MW-1:0];
    sol_tvalid = 0; sol_tlast = 0;
    rref_done = 1; rref_inconsistent = incons; rref_result = res;
    tick();
    rref_done = 0; rref_inconsistent = 0;
    if (incons) begin
      chk_ctl("nosol_report", C_WV);
      check("nosol_flag", {a_nos, b_nos}, 2'b11);
      check("nosol_wt", {a_wt, b_wt}, 8'h00);
    end else begin
      chk_ctl("enum_go", C_ES);
      check("enum_rref", {a_em, b_em}, {res, res});
      check("enum_dims", {a_er, a_ec, b_er, b_ec}, {4'(rows), 4'(cols), 4'(rows), 4'(cols)});
      exp_wt = 99;
      for (int k = 0; k < beats.size(); k++) begin
        if ($countones(beats[k]) < exp_wt) exp_wt = $countones(beats[k]);
        n = $urandom_range(0, 2);
        for (int g = 0; g < n; g++) begin
          sol_tvalid = 0; rref_done = stray; rref_inconsistent = stray;
          tick();
          rref_done = 0; rref_inconsistent = 0;
          chk_ctl("collect_gap", C_TR);
        end
        sol_tvalid = 1; sol_tdata = beats[k]; sol_tlast = (k == beats.size() - 1);
        n = 0;
        do begin
          rdy = a_tr;
          tick();
          n++;
        end while (!rdy && n < 8);
        if (!rdy) check("tready_timeout", 0, 1);
        sol_tvalid = 0; sol_tlast = 0;
        if (k == abort) begin
          rst_n = 0; tick(); rst_n = 1;
          bsum = 0; prev_last = 0;
          chk_ctl("in_reset", C_RDY);
          for (int c = 0; c < 3; c++) begin tick(); chk_ctl("after_reset", C_RDY); end
          chk_tot("after_reset");
          return;
        end
        if (k != beats.size() - 1) chk_ctl("collect_beat", C_TR);
      end
      chk_ctl("report", C_WV);
      check("job_wt16", a_wt, exp_wt);
      check("job_wt2", b_wt, exp_wt);
      check("job_nosol", {a_nos, b_nos}, 2'b00);
      bsum += exp_wt;
    end
    tick();
    if (last) begin
      chk_ctl("done", C_TV);
      chk_tot("done");
      tick();
    end
    chk_ctl("back_idle", C_RDY);
    chk_tot("held");
  endtask

  function automatic logic [MW-1:0] rnd_mat();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[MW-1:0];
  endfunction

  initial begin
    logic [7:0] mask;
    int nb;
    repeat (3) tick();
    chk_ctl("reset_hold", C_RDY);
    rst_n = 1;
    tick();
    chk_ctl("reset", C_RDY);
    chk_tot("reset");
    check("reset_wt", {a_wt, a_nos, b_wt, b_nos}, 10'h0);
    check("reset_ops", {a_rm, a_em, a_rr, a_rc, a_er, a_ec}, '0);

    beats = '{8'hA0, 8'h60, 8'hF0, 8'h10};
    run_job(4, 9, rnd_mat(), 1, 0, 1, 0, -1);
    beats = '{8'h03, 8'hE3, 8'h0F};
    run_job(3, 5, rnd_mat(), 0, 0, 0, 1, -1);
    beats = '{8'hE0, 8'hF0};
    run_job(8, 9, rnd_mat(), 1, 0, 2, 0, -1);
    beats = '{8'h00};
    run_job(2, 3, rnd_mat(), 1, 0, 0, 0, -1);
    beats = '{8'h18};
    run_job(3, 4, rnd_mat(), 0, 0, 1, 0, -1);
    run_job(3, 4, rnd_mat(), 0, 1, 1, 1, -1);
    beats = '{8'h07, 8'hFF};
    run_job(5, 9, rnd_mat(), 1, 0, 0, 0, -1);
    beats = '{8'h07};
    run_job(6, 9, rnd_mat(), 0, 0, 0, 0, -1);
    beats = '{8'h03};
    run_job(6, 9, rnd_mat(), 1, 0, 0, 0, -1);
    beats = '{8'h81, 8'h01};
    run_job(1, 2, rnd_mat(), 1, 0, 0, 0, -1);
    beats = '{8'hF0, 8'h0F, 8'h01};
    run_job(4, 9, rnd_mat(), 0, 0, 1, 0, 1);
    beats = '{8'h0C};
    run_job(4, 9, rnd_mat(), 1, 0, 0, 0, -1);

    for (int j = 0; j < 40; j++) begin
      int cols;
      cols = $urandom_range(2, MC);
      mask = 8'hFF << (MC - cols);
      nb = $urandom_range(1, 6);
      beats = {};
      for (int k = 0; k < nb; k++) beats.push_back(8'($urandom()) & mask);
      run_job($urandom_range(1, MR), cols, rnd_mat(), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 4) == 0), $urandom_range(0, 3), $urandom_range(0, 1),
              (j % 13 == 12 && nb > 1) ? 0 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
